// File: rtl/multiplier_pkg.sv
// Shared definitions for the repeated-addition multiplier controller.
// State encodings are binary and fixed so other blocks can decode them.
package multiplier_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      StIdle   = 2'd0,
      StLoad   = 2'd1,
      StRun    = 2'd2,
      StFinish = 2'd3
   } state_e;

   function automatic logic state_is_busy(input state_e st);
      return (st != StIdle);
   endfunction

endpackage

// File: rtl/multiplier_sequencer_rising_edge_detect.sv
// Registered previous value plus a rising-edge pulse, with synchronous reset.
// Shared by the button-driven controllers.
module rising_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic level_i,
   output logic pulse_o
);

   logic prev_q, prev_d;

   always_comb begin
      prev_d = level_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign pulse_o = level_i & ~prev_q;

endmodule

// File: rtl/multiplier_sequencer.sv
// Controller for the repeated-addition multiplier: latches operands, drives the
// accumulator clear/enable for min(a,b) cycles of adding max(a,b), then captures the product.
module multiplier_sequencer
   import multiplier_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic [2*N-1:0] accValue,
   output logic [N-1:0]   addend,
   output logic           accClear,
   output logic           accEnable,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);

   state_e         state_q, state_d;
   logic [N-1:0]   op_min_q, op_min_d;
   logic [N-1:0]   op_max_q, op_max_d;
   logic [N-1:0]   count_q, count_d;
   logic [2*N-1:0] product_q, product_d;
   logic           done_q, done_d;
   logic           start_rise;
   logic           launch;

   rising_edge_detect u_start_edge (
      .clk     (clk),
      .reset   (reset),
      .level_i (start),
      .pulse_o (start_rise)
   );

   // Edges arriving while an operation is in flight are dropped, not queued.
   assign launch = start_rise & (state_q == StIdle);

   always_comb begin
      state_d   = state_q;
      op_min_d  = op_min_q;
      op_max_d  = op_max_q;
      count_d   = count_q;
      product_d = product_q;
      done_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (launch) begin
               if (a < b) begin
                  op_min_d = a;
                  op_max_d = b;
               end else begin
                  op_min_d = b;
                  op_max_d = a;
               end
               state_d = StLoad;
            end
         end
         StLoad: begin
            count_d = '0;
            state_d = (op_min_q == '0) ? StFinish : StRun;
         end
         StRun: begin
            count_d = count_q + N'(1);
            if (count_q == op_min_q - N'(1)) begin
               state_d = StFinish;
            end
         end
         StFinish: begin
            product_d = accValue;
            done_d    = 1'b1;
            state_d   = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         op_min_q  <= '0;
         op_max_q  <= '0;
         count_q   <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_min_q  <= op_min_d;
         op_max_q  <= op_max_d;
         count_q   <= count_d;
         product_q <= product_d;
         done_q    <= done_d;
      end
   end

   // Reset overrides the state decode so the accumulator is cleared and frozen immediately.
   assign accClear  = reset | (state_q == StLoad);
   assign accEnable = ~reset & (state_q == StRun);
   assign busy      = state_is_busy(state_q);
   assign addend    = op_max_q;
   assign done      = done_q;
   assign product   = product_q;

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Self-checking bench: models the accumulator datapath and compares against a*b timing rules.
module tb_multiplier_sequencer;

   localparam int unsigned N = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [N-1:0]   a, b;
   logic [2*N-1:0] acc_model;
   logic [N-1:0]   addend;
   logic           accClear, accEnable, busy, done;
   logic [2*N-1:0] product;

   int n_checks = 0;
   int n_fail   = 0;

   multiplier_sequencer #(.N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .a         (a),
      .b         (b),
      .accValue  (acc_model),
      .addend    (addend),
      .accClear  (accClear),
      .accEnable (accEnable),
      .busy      (busy),
      .done      (done),
      .product   (product)
   );

   always #5 clk = ~clk;

   // Datapath stand-in: 2N-bit accumulator with clear and add-enable.
   always @(posedge clk) begin
      if (accClear) acc_model <= '0;
      else if (accEnable) acc_model <= acc_model + {{N{1'b0}}, addend};
   end

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      int           prod;
      int           lat;
      int           en;
      int           add;
   } vec_t;

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [N-1:0] x, input logic [N-1:0] y);
      a     = x;
      b     = y;
      start = 1'b1;
   endtask

   // Called in the launch cycle; returns in the done cycle (or after a timeout).
   task automatic run_check(input string nm, input int exp_add, input int exp_lat,
                            input int exp_en, input int exp_prod, input bit hold,
                            input bit scramble, input int glitch);
      int k = 0;
      int en = 0;
      int busy_bad = 0;
      int add_bad = 0;
      bit seen = 0;
      while (!seen && k < 60) begin
         step();
         k++;
         if (hold) start = 1'b1;
         else start = (glitch != 0 && k == glitch);
         if (scramble) begin
            a = N'($urandom);
            b = N'($urandom);
         end
         if (done) begin
            seen = 1;
         end else begin
            if (!busy) busy_bad++;
            if (accEnable) begin
               en++;
               if (int'(addend) != exp_add) add_bad++;
            end
         end
      end
      check({nm, " done seen"}, int'(seen), 1);
      check({nm, " latency"}, k, exp_lat);
      check({nm, " enable cycles"}, en, exp_en);
      check({nm, " product"}, int'(product), exp_prod);
      check({nm, " busy low at done"}, int'(busy), 0);
      check({nm, " busy gaps"}, busy_bad, 0);
      check({nm, " addend while enabled"}, add_bad, 0);
      check({nm, " addend held"}, int'(addend), exp_add);
   endtask

   task automatic idle(input string nm, input int n);
      for (int i = 0; i < n; i++) begin
         step();
         check({nm, " done low"}, int'(done), 0);
         check({nm, " busy low"}, int'(busy), 0);
      end
   endtask

   function automatic vec_t model(input logic [N-1:0] x, input logic [N-1:0] y);
      vec_t v;
      int mn = (x < y) ? int'(x) : int'(y);
      int mx = (x < y) ? int'(y) : int'(x);
      v.a    = x;
      v.b    = y;
      v.prod = int'(x) * int'(y);
      v.lat  = mn + 3;
      v.en   = mn;
      v.add  = mx;
      return v;
   endfunction

   vec_t table_v[5];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      table_v[0] = '{a: 4'd3,  b: 4'd5,  prod: 15,  lat: 6,  en: 3,  add: 5};
      table_v[1] = '{a: 4'd0,  b: 4'd9,  prod: 0,   lat: 3,  en: 0,  add: 9};
      table_v[2] = '{a: 4'd9,  b: 4'd0,  prod: 0,   lat: 3,  en: 0,  add: 9};
      table_v[3] = '{a: 4'd15, b: 4'd15, prod: 225, lat: 18, en: 15, add: 15};
      table_v[4] = '{a: 4'd2,  b: 4'd7,  prod: 14,  lat: 5,  en: 2,  add: 7};

      reset = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      step();
      step();
      check("reset product", int'(product), 0);
      check("reset done", int'(done), 0);
      check("reset busy", int'(busy), 0);
      check("reset accClear", int'(accClear), 1);
      check("reset accEnable", int'(accEnable), 0);
      reset = 1'b0;
      #1;
      check("idle accClear", int'(accClear), 0);

      for (int i = 0; i < 5; i++) begin
         launch(table_v[i].a, table_v[i].b);
         run_check($sformatf("vec%0d", i), table_v[i].add, table_v[i].lat, table_v[i].en,
                   table_v[i].prod, 1'b0, 1'b0, 0);
         idle($sformatf("vec%0d after", i), 2);
      end

      for (int i = 0; i < 20; i++) begin
         vec_t v;
         v = model(N'($urandom), N'($urandom));
         launch(v.a, v.b);
         run_check($sformatf("rand%0d", i), v.add, v.lat, v.en, v.prod, 1'b0, 1'b0, 0);
         idle($sformatf("rand%0d after", i), 1);
      end

      // Start held high through and past completion: one operation only.
      launch(4'd5, 4'd4);
      run_check("hold", 5, 7, 4, 20, 1'b1, 1'b0, 0);
      idle("hold after", 4);
      start = 1'b0;
      idle("hold release", 1);

      // Fresh rising edge mid-operation must be ignored.
      launch(4'd6, 4'd5);
      run_check("glitch", 6, 8, 5, 30, 1'b0, 1'b0, 3);
      idle("glitch after", 12);

      // Rising edge in the done cycle launches back-to-back.
      launch(4'd3, 4'd5);
      run_check("relaunch first", 5, 6, 3, 15, 1'b0, 1'b0, 0);
      launch(4'd2, 4'd7);
      run_check("relaunch second", 7, 5, 2, 14, 1'b0, 1'b0, 0);
      idle("relaunch after", 2);

      // Reset in the middle of RUN.
      launch(4'd6, 4'd6);
      for (int i = 0; i < 4; i++) begin
         step();
         start = 1'b0;
      end
      check("midrun accEnable before reset", int'(accEnable), 1);
      reset = 1'b1;
      #1;
      check("midrun accClear in reset", int'(accClear), 1);
      check("midrun accEnable in reset", int'(accEnable), 0);
      step();
      reset = 1'b0;
      #1;
      check("midrun product cleared", int'(product), 0);
      check("midrun done", int'(done), 0);
      check("midrun busy", int'(busy), 0);
      check("midrun accEnable", int'(accEnable), 0);
      idle("midrun idle", 1);
      launch(4'd6, 4'd6);
      run_check("post reset", 6, 9, 6, 36, 1'b0, 1'b0, 0);
      idle("post reset after", 1);

      // Operands wiggle every cycle after launch.
      launch(4'd4, 4'd3);
      run_check("scramble", 4, 6, 3, 12, 1'b0, 1'b1, 0);
      a = '0;
      b = '0;
      idle("scramble after", 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multiplier_sequencer.md
Name: multiplier_sequencer

Overview:
FSM controller for the repeated-addition multiplier datapath (2N-bit accumulator register plus adder).
- Latches operands on a start request.
- Picks the smaller operand as the iteration count and the larger as the addend, so add cycles are minimised.
- Drives the accumulator's clear and enable, then captures the finished product and raises a one-cycle done pulse.
- Sits between the debounced evaluate button and the accumulator/adder; its product output feeds the hex display decoders.

Parameters:
N, 4, operand width in bits; product and accumulator width is 2N.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request, already debounced; only a rising edge (0 then 1 on consecutive cycles) launches an operation.
a  input  N  multiplicand, sampled only on the launching cycle.
b  input  N  multiplier, sampled only on the launching cycle.
accValue  input  2N  current accumulator register output from the datapath.
addend  output  N  value the datapath adds each enabled cycle (max of latched operands).
accClear  output  1  synchronous clear to the accumulator.
accEnable  output  1  accumulator load enable (acc <= acc + addend).
busy  output  1  high from the cycle after launch until done is asserted.
done  output  1  one-cycle completion pulse.
product  output  2N  registered result; holds its value until the next completion.

Behaviour:
- States: IDLE, LOAD, RUN, FINISH. Encoding is binary, from the shared package.
- Reset (synchronous, any state, including mid-RUN):
  - state=IDLE; product=0; done=0; count=0; operand registers=0; start-history register=0.
  - accClear=1 while reset is high; accEnable=0.
- Launch detection: startPrev is registered each cycle. launch = start & ~startPrev & (state==IDLE).
  - Rising edges while not IDLE are ignored and not queued.
  - Start held high launches exactly one operation.
- IDLE: busy=0, accClear=0, accEnable=0. On launch: opMin<=min(a,b), opMax<=max(a,b); next state LOAD.
- LOAD (1 cycle): accClear=1, count<=0, busy=1.
  - Next state FINISH if opMin==0, else RUN.
- RUN: accEnable=1, count<=count+1 each cycle.
  - When count==opMin-1, next state is FINISH. This gives exactly opMin enabled cycles.
  - count is N bits and never wraps, since opMin <= 2^N-1.
- FINISH (1 cycle): accEnable=0, busy=1.
  - At the closing edge: product<=accValue, done<=1, state<=IDLE.
- done is high for exactly the one cycle after FINISH and is cleared the following edge.
  - A launch is accepted in that same cycle, since state is already IDLE.
- addend = opMax combinationally from the latched register. It is stable for the whole operation and holds its last value in IDLE.
- Ties (a==b): opMin=opMax=a.
- Timing, launch edge at end of cycle 0:
  - LOAD in cycle 1; RUN in cycles 2..opMin+1; FINISH in cycle opMin+2.
  - done/product valid in cycle opMin+3. Total latency is opMin+3 cycles.
- a and b changes after launch have no effect.
- accValue is only sampled in FINISH.

Decomposition:
- Shared package multiplier_pkg: state encodings (IDLE=0, LOAD=1, RUN=2, FINISH=3) and STATE_W=2.
- One sub-module, rising_edge_detect: registered previous value plus pulse output, with synchronous reset. It is reused by other button-driven controllers.
- The min/max compare stays inline.

Test Plan:
Bench models the accumulator: clear -> 0; enable -> acc+addend.
1. Basic: a=3, b=5, rising start -> addend=5, accEnable high 3 cycles, done pulse in cycle 6 after launch, product=15.
2. Zero operand: a=0, b=9 -> no accEnable cycles, done in cycle 3, product=0. Repeat with a=9, b=0, same result.
3. Max operands: a=15, b=15, N=4 -> 15 enable cycles, product=225, done in cycle 18, busy high cycles 1..17.
4. Start handling: hold start high across the whole operation -> exactly one done. A start pulse while busy is ignored. A new rising edge in the done cycle launches a second operation, a=2, b=7 -> product=14.
5. Reset mid-RUN: a=6, b=6, assert reset in cycle 4 -> next cycle IDLE, product=0, done=0, busy=0, accClear=1 during reset. A fresh start afterwards gives product=36.
6. Operand stability: change a and b every cycle after launch (launched values 4 and 3) -> product=12.
